register_file_32: RTL and testbench
===================================

Name: register_file_32

Overview:
- 32-entry general-purpose register file for the datapath.
- Sits directly downstream of the write-back select stage: the 5-bit destination-select mux feeds `write_register`, and the 32-bit write-back mux feeds `write_data`.
- Its two read ports feed the ALU operand select muxes.
- Contains a sequential clear engine that zeroes every entry after reset before the processor may issue writes.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDRESS_WIDTH, 5, register index width; depth is 2**ADDRESS_WIDTH (32).

Ports:
- clk  input  1  system clock, all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- read_register_1  input  ADDRESS_WIDTH  index for read port 1
- read_register_2  input  ADDRESS_WIDTH  index for read port 2
- write_register  input  ADDRESS_WIDTH  destination index from the destination-select mux
- write_data  input  DATA_WIDTH  write-back value from the write-back mux
- register_write  input  1  write enable for the current cycle
- read_data_1  output  DATA_WIDTH  contents of read_register_1
- read_data_2  output  DATA_WIDTH  contents of read_register_2
- ready  output  1  high once the clear sequence has finished; writes are accepted only while high

Behaviour:
- One clock. Reset is synchronous and active-high: sampled only on the rising edge of clk.
- State machine has two states, CLEAR and RUN.
  - Reset asserted at an edge: state <= CLEAR, clear_index <= 0, ready <= 0.
- CLEAR state:
  - Each edge: entry[clear_index] <= 0, clear_index <= clear_index + 1.
  - At the edge where clear_index == 31, the entry is written and the state moves to RUN; ready <= 1 on that same edge.
  - Total 32 cycles from reset deassertion to ready = 1.
  - clear_index is ADDRESS_WIDTH bits wide; its wrap to 0 is not used as the exit condition.
- Reset during CLEAR or RUN: restart the sequence at clear_index 0. Partially cleared or written contents are not preserved.
- While ready == 0:
  - register_write is ignored.
  - read_data_1 and read_data_2 are forced to 0.
- RUN state, write: at a rising edge with register_write == 1 and write_register != 0, entry[write_register] <= write_data.
- Entry 0:
  - Hardwired zero; writes to index 0 are silently discarded.
  - Reads of index 0 always return 0, in every state and in both build variants.
- Reads are combinational (zero latency) from the current entry contents.
- Without bypass, a write is visible on the read ports from the cycle after the write edge.
- Both read ports may address the same entry, or the entry being written, in the same cycle. There are no port conflicts.
- No other outputs exist. After reset, read_data_1 = read_data_2 = 0 and ready = 0.

Optional Feature:
- Macro: REGISTER_FILE_BYPASS_EN.
- Defined: write-to-read bypass.
  - Condition per read port x: ready == 1, register_write == 1, write_register != 0, and write_register == read_register_x.
  - When the condition holds, read_data_x = write_data combinationally in the same cycle.
  - This supports same-cycle write-back/decode without a separate forwarding path.
- Not defined: no bypass. Read ports show the stored value until the edge after the write.

Test Plan:
- Reset for 1 cycle, then deassert; count cycles -> ready rises exactly 32 cycles after deassertion. Read all 32 indices -> every read returns 0x00000000.
- After ready: write 0xDEADBEEF to register 5, then read ports 1 and 2 both at register 5 next cycle -> both return 0xDEADBEEF. Also check the write cycle itself: without the macro, read of register 5 during that cycle returns 0; with REGISTER_FILE_BYPASS_EN it returns 0xDEADBEEF.
- Write 0x12345678 to register 0 -> read of register 0 returns 0 the next cycle and thereafter; with bypass enabled it also returns 0 during the write cycle.
- Assert register_write with register 7 / 0xAAAA5555 at cycle 10 after reset (ready == 0) -> register 7 reads 0 after ready; read ports return 0 throughout CLEAR.
- Fill registers 1..31 with their index value, then assert reset for 1 cycle at cycle 15 of a new clear sequence and again during RUN -> ready drops the following edge; after 32 more cycles all registers read 0.
- Write register 3 = 0x1 and register 4 = 0xFFFFFFFF on consecutive cycles, reading 3 on port 1 and 4 on port 2 -> port 1 = 0x00000001, port 2 = 0xFFFFFFFF, with no interference between ports.

Source files
------------

// File: rtl/register_file_32_if.sv
// register_file_32_if: read/write port bundle between the write-back stage,
// the register file and the ALU operand muxes.
interface register_file_32_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic [ADDRESS_WIDTH-1:0] read_register_1;
  logic [ADDRESS_WIDTH-1:0] read_register_2;
  logic [ADDRESS_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     register_write;
  logic [DATA_WIDTH-1:0]    read_data_1;
  logic [DATA_WIDTH-1:0]    read_data_2;
  logic                     ready;

  modport master (
    output read_register_1, read_register_2, write_register, write_data, register_write,
    input  read_data_1, read_data_2, ready
  );

  modport slave (
    input  read_register_1, read_register_2, write_register, write_data, register_write,
    output read_data_1, read_data_2, ready
  );
endinterface

// File: rtl/register_file_32.sv
// register_file_32: 32-entry register file that zeroes itself after reset.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file_32 #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  register_file_32_if.slave rf
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_INDEX = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = {ADDRESS_WIDTH{1'b1}};
  localparam logic [ADDRESS_WIDTH-1:0] ONE_INDEX  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]    ZERO_DATA  = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [ADDRESS_WIDTH-1:0] clear_index_r;
  logic [ADDRESS_WIDTH-1:0] clear_index_next_s;
  logic                     ready_r;
  logic                     ready_next_s;
  logic [DATA_WIDTH-1:0]    entry_r [DEPTH];
  logic                     mem_we_s;
  logic [ADDRESS_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0]    mem_data_s;
  logic                     bypass_1_s;
  logic                     bypass_2_s;

  // Index 0 and the not-ready window always read as zero; bypass overrides storage.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDRESS_WIDTH-1:0] index,
    input logic [DATA_WIDTH-1:0]    stored,
    input logic                     valid,
    input logic                     bypass,
    input logic [DATA_WIDTH-1:0]    forward
  );
    logic [DATA_WIDTH-1:0] result;
    if (!valid || index == ZERO_INDEX) begin
      result = ZERO_DATA;
    end else if (bypass) begin
      result = forward;
    end else begin
      result = stored;
    end
    return result;
  endfunction

`ifdef REGISTER_FILE_BYPASS_EN
  assign bypass_1_s = ready_r && rf.register_write && (rf.write_register != ZERO_INDEX)
                      && (rf.write_register == rf.read_register_1);
  assign bypass_2_s = ready_r && rf.register_write && (rf.write_register != ZERO_INDEX)
                      && (rf.write_register == rf.read_register_2);
`else
  assign bypass_1_s = 1'b0;
  assign bypass_2_s = 1'b0;
`endif

  // Next-state logic: walk the clear pointer, then accept write-back in RUN.
  always_comb begin
    state_next_s       = state_r;
    clear_index_next_s = clear_index_r;
    ready_next_s       = ready_r;
    mem_we_s           = 1'b0;
    mem_addr_s         = rf.write_register;
    mem_data_s         = rf.write_data;
    case (state_r)
      CLEAR: begin
        mem_we_s           = 1'b1;
        mem_addr_s         = clear_index_r;
        mem_data_s         = ZERO_DATA;
        clear_index_next_s = clear_index_r + ONE_INDEX;
        if (clear_index_r == LAST_INDEX) begin
          state_next_s = RUN;
          ready_next_s = 1'b1;
        end else begin
          state_next_s = CLEAR;
          ready_next_s = 1'b0;
        end
      end
      RUN: begin
        ready_next_s = 1'b1;
        if (rf.register_write && rf.write_register != ZERO_INDEX) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_next_s       = CLEAR;
        clear_index_next_s = ZERO_INDEX;
        ready_next_s       = 1'b0;
      end
    endcase
  end

  // Control state register with synchronous restart of the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= CLEAR;
      clear_index_r <= ZERO_INDEX;
      ready_r       <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      clear_index_r <= clear_index_next_s;
      ready_r       <= ready_next_s;
    end
  end

  // Entry storage; contents are rebuilt by the clear engine rather than reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_s) begin
      entry_r[mem_addr_s] <= mem_data_s;
    end
  end

  assign rf.ready       = ready_r;
  assign rf.read_data_1 = read_port(rf.read_register_1, entry_r[rf.read_register_1],
                                    ready_r, bypass_1_s, rf.write_data);
  assign rf.read_data_2 = read_port(rf.read_register_2, entry_r[rf.read_register_2],
                                    ready_r, bypass_2_s, rf.write_data);
endmodule

// File: tb/tb_register_file_32.sv
// tb_register_file_32: directed plan plus randomized traffic against an
// array-based reference model of the register file.
module tb_register_file_32;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  register_file_32_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) rf_if ();

  register_file_32 #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: plain array plus a countdown of edges until ready.
  logic [31:0] m_mem [32];
  bit          m_ready      = 1'b0;
  int          m_clear_left = 0;
  bit          m_valid      = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (!m_ready || ra == 5'd0) return 32'h0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (we && wa != 5'd0 && wa == ra) return wd;
`endif
    return m_mem[ra];
  endfunction

  // One clock: drive, check combinational reads mid-cycle, then advance the model.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    reset                 = rst;
    rf_if.register_write  = we;
    rf_if.write_register  = wa;
    rf_if.write_data      = wd;
    rf_if.read_register_1 = ra1;
    rf_if.read_register_2 = ra2;
    @(negedge clk);
    if (m_valid) begin
      check_eq("ready", {31'd0, rf_if.ready}, {31'd0, m_ready});
      check_eq("rd1", rf_if.read_data_1, exp_rd(ra1, we, wa, wd));
      check_eq("rd2", rf_if.read_data_2, exp_rd(ra2, we, wa, wd));
    end
    @(posedge clk);
    if (rst) begin
      m_valid      = 1'b1;
      m_ready      = 1'b0;
      m_clear_left = 32;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else if (!m_ready) begin
      m_clear_left--;
      if (m_clear_left == 0) m_ready = 1'b1;
    end else if (we && wa != 5'd0) begin
      m_mem[wa] = wd;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, ra1, ra2);
  endtask

  initial begin
    int n;
    rf_if.register_write  = 1'b0;
    rf_if.write_register  = 5'd0;
    rf_if.write_data      = 32'h0;
    rf_if.read_register_1 = 5'd0;
    rf_if.read_register_2 = 5'd0;

    // Reset, count cycles to ready, and try a write while still clearing.
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n = 0;
    while (rf_if.ready !== 1'b1 && n < 100) begin
      if (n == 10) cycle(1'b0, 1'b1, 5'd7, 32'hAAAA5555, 5'd7, 5'd7);
      else         cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'(n));
      n++;
    end
    check_eq("ready_latency", 32'(n), 32'd32);

    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      check_eq("cleared_rd1", rf_if.read_data_1, 32'h0);
      check_eq("cleared_rd2", rf_if.read_data_2, 32'h0);
    end
    idle(5'd7, 5'd7);
    check_eq("clear_write_ignored", rf_if.read_data_1, 32'h0);

    // Basic write, visible on both ports the next cycle.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    idle(5'd5, 5'd5);
    check_eq("r5_port1", rf_if.read_data_1, 32'hDEADBEEF);
    check_eq("r5_port2", rf_if.read_data_2, 32'hDEADBEEF);

    // Writes to register 0 are discarded.
    cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    check_eq("r0_after_write", rf_if.read_data_1, 32'h0);

    // Back-to-back writes to different entries, read on separate ports.
    cycle(1'b0, 1'b1, 5'd3, 32'h00000001, 5'd3, 5'd4);
    cycle(1'b0, 1'b1, 5'd4, 32'hFFFFFFFF, 5'd3, 5'd4);
    idle(5'd3, 5'd4);
    check_eq("r3_port1", rf_if.read_data_1, 32'h00000001);
    check_eq("r4_port2", rf_if.read_data_2, 32'hFFFFFFFF);

    // Fill with index values, then reset in RUN and again mid-clear.
    for (int i = 1; i < 32; i++) cycle(1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
    idle(5'd31, 5'd17);
    check_eq("fill_r31", rf_if.read_data_1, 32'd31);
    check_eq("fill_r17", rf_if.read_data_2, 32'd17);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check_eq("ready_drop_run", {31'd0, rf_if.ready}, 32'd0);
    for (int i = 0; i < 15; i++) idle(5'd9, 5'd31);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check_eq("ready_low_mid_clear", {31'd0, rf_if.ready}, 32'd0);
    for (int i = 0; i < 32; i++) idle(5'd1, 5'd2);
    check_eq("ready_after_reclear", {31'd0, rf_if.ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(i));
      check_eq("recleared", rf_if.read_data_1, 32'h0);
    end

    // Randomized traffic with occasional resets and address collisions.
    for (int k = 0; k < 600; k++) begin
      logic        r_rst;
      logic        r_we;
      logic [4:0]  r_wa;
      logic [31:0] r_wd;
      logic [4:0]  r_ra1;
      logic [4:0]  r_ra2;
      r_rst = ($urandom_range(0, 99) == 0);
      r_we  = 1'($urandom_range(0, 1));
      r_wa  = 5'($urandom);
      r_wd  = $urandom;
      r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom);
      r_ra2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom);
      cycle(r_rst, r_we, r_wa, r_wd, r_ra1, r_ra2);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
